uart_stream_arb: RTL and testbench

Round-robin, packet-level arbiter sharing the single AXI-Stream UART transmitter slave (32-bit TDATA in, serial txd out) between up to `NUM_REQ` requester streams. It sits directly in front of the transmitter's S_AXIS port. It locks the grant to one requester from its first accepted beat through its TLAST beat, so packets from different sources never interleave on the UART line. Data passes through combinationally once granted, so the block adds no latency per beat.

---
 rtl/uart_stream_arb.sv | 146 ++++++++++++++
 tb/tb_uart_stream_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_arb.sv
// Round-robin, packet-locked arbiter feeding one AXI-Stream UART transmitter from NUM_REQ streams.
// Define UART_ARB_TIMEOUT_EN to force release of a granted requester that stalls TIMEOUT_CYCLES cycles.
module uart_stream_arb #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        S_AXIS_ACLK,
  input  logic                        S_AXIS_ARESETN,
  input  logic [NUM_REQ-1:0]          S_AXIS_TVALID,
  input  logic [NUM_REQ*DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [NUM_REQ-1:0]          S_AXIS_TLAST,
  output logic [NUM_REQ-1:0]          S_AXIS_TREADY,
  output logic                        M_AXIS_TVALID,
  output logic [DATA_W-1:0]           M_AXIS_TDATA,
  output logic                        M_AXIS_TLAST,
  input  logic                        M_AXIS_TREADY,
  output logic [$clog2(NUM_REQ)-1:0]  grant,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_stream_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q,  last_d;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            found;
  int              idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    pick          = '0;
    cand          = '0;
    found         = 1'b0;
    idx           = 0;
    S_AXIS_TREADY = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_d   = '0;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Search starts one past the previous owner so every requester gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = int'(last_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          cand = GW'(idx);
          if (!found && S_AXIS_TVALID[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          state_d = ST_XFER;
          grant_d = pick;
        end
      end

      ST_XFER: begin
        M_AXIS_TVALID          = S_AXIS_TVALID[grant_q];
        M_AXIS_TDATA           = S_AXIS_TDATA[int'(grant_q)*DATA_W +: DATA_W];
        M_AXIS_TLAST           = S_AXIS_TLAST[grant_q];
        S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;

        if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent source counts as a stall; transmitter backpressure never does.
        if (S_AXIS_TVALID[grant_q]) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          last_d        = grant_q;
          timeout_err_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant = grant_q;
  assign busy  = (state_q == ST_XFER);

endmodule

// File: tb/tb_uart_stream_arb.sv
// Directed self-checking bench for uart_stream_arb: single packet, round-robin, backpressure,
// mid-packet reset and stall handling (timeout behaviour follows UART_ARB_TIMEOUT_EN).
module tb_uart_stream_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      s_tvalid;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic              m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        grant;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  // Bench-side requester model: current beat, packet length, active flag, repeat flag.
  int beat [N];
  int plen [N];
  bit act  [N];
  bit rep  [N];

  uart_stream_arb #(
    .NUM_REQ       (N),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i, input int b);
    return (32'(i) << 28) | 32'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]          = act[i];
      s_tdata[i*DW +: DW]  = word(i, beat[i]);
      s_tlast[i]           = act[i] && (beat[i] == plen[i] - 1);
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic advance(input logic [N-1:0] hs);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        beat[i]++;
        if (beat[i] == plen[i]) begin
          beat[i] = 0;
          if (!rep[i]) act[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_cycle();
    settle();
    advance(s_tready & s_tvalid);
    tick();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      plen[i] = 1;
      act[i]  = 1'b0;
      rep[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    settle();
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] w1 [3];
  logic [31:0] rx [6];
  int          exp_g [5];
  int          idle_run;
  int          npk;
  int          nrx;
  int          n;
  bit          prev_busy;
  bit          tr0_bad;
  logic [N-1:0] hs;

  initial begin
    w1[0] = 32'haabbccdd;
    w1[1] = 32'h11223344;
    w1[2] = 32'h55667788;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;

    // ---- Reset then single 3-beat packet from requester 2
    rst_n    = 1'b0;
    m_tready = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_grant", grant, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_s_tready", s_tready, 0);
    check("reset_timeout_err", timeout_err, 0);

    rst_n             = 1'b1;
    m_tready          = 1'b1;
    s_tvalid          = 4'b0100;
    s_tdata[64 +: 32] = w1[0];
    #1;
    check("idle_m_tvalid", m_tvalid, 0);
    check("idle_s_tready", s_tready, 0);
    for (int b = 0; b < 3; b++) begin
      tick();
      s_tdata[64 +: 32] = w1[b];
      s_tlast[2]        = (b == 2);
      #1;
      check("single_grant", grant, 2);
      check("single_m_tvalid", m_tvalid, 1);
      check("single_m_tdata", m_tdata, w1[b]);
      check("single_m_tlast", m_tlast, (b == 2));
      check("single_s_tready", s_tready, 4'b0100);
    end
    tick();
    s_tvalid = '0;
    s_tlast  = '0;
    #1;
    check("single_busy_falls", busy, 0);
    check("single_grant_kept", grant, 2);
    check("single_m_tvalid_low", m_tvalid, 0);

    // ---- Round-robin: all four requesters stream 2-beat packets
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      act[i]  = 1'b1;
      rep[i]  = 1'b1;
      plen[i] = 2;
    end
    m_tready = 1'b1;
    do_reset();
    settle();
    idle_run  = 0;
    npk       = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 60 && npk < 5; c++) begin
      if (!busy) begin
        idle_run++;
      end else if (!prev_busy) begin
        check("rr_grant", grant, exp_g[npk]);
        check("rr_bubble", idle_run, 1);
        npk++;
        idle_run = 0;
      end
      if (m_tvalid && m_tready) check("rr_data", m_tdata, word(int'(grant), beat[grant]));
      hs        = s_tready & s_tvalid;
      prev_busy = busy;
      advance(hs);
      tick();
      settle();
    end
    check("rr_packets", npk, 5);

    // ---- Backpressure: requester 1 owns a 4-beat packet while requester 0 waits
    clear_reqs();
    act[1]  = 1'b1;
    plen[1] = 4;
    m_tready = 1'b0;
    do_reset();
    nrx     = 0;
    tr0_bad = 1'b0;
    for (int c = 0; c < 200 && nrx < 6; c++) begin
      m_tready = (c % 10 == 0);
      if (c == 2) begin
        act[0]  = 1'b1;
        plen[0] = 2;
      end
      settle();
      if (s_tready[0] && nrx < 4) tr0_bad = 1'b1;
      if (m_tvalid && m_tready) begin
        rx[nrx] = m_tdata;
        nrx++;
      end
      advance(s_tready & s_tvalid);
      tick();
    end
    check("bp_word_count", nrx, 6);
    for (int k = 0; k < 4; k++) check("bp_req1_word", rx[k], word(1, k));
    for (int k = 0; k < 2; k++) check("bp_req0_word", rx[4+k], word(0, k));
    check("bp_req0_ready_low", tr0_bad, 0);

    // ---- Reset in the middle of a 4-beat packet from requester 3
    clear_reqs();
    act[3]   = 1'b1;
    plen[3]  = 4;
    m_tready = 1'b1;
    do_reset();
    run_cycle();
    run_cycle();
    run_cycle();
    check("mid_beats_sent", beat[3], 2);
    rst_n = 1'b0;
    settle();
    check("mid_pre_reset_valid", m_tvalid, 1);
    tick();
    rst_n  = 1'b1;
    act[1] = 1'b1;
    settle();
    check("mid_m_tvalid", m_tvalid, 0);
    check("mid_busy", busy, 0);
    check("mid_grant", grant, 0);
    tick();
    settle();
    check("mid_rearb_grant", grant, 1);
    check("mid_rearb_busy", busy, 1);

    // ---- Granted requester 0 goes silent after its first beat; requester 2 waits
    clear_reqs();
    act[0]   = 1'b1;
    plen[0]  = 4;
    m_tready = 1'b1;
    do_reset();
    run_cycle();
    run_cycle();
    act[0]  = 1'b0;
    act[2]  = 1'b1;
    settle();
    check("stall_start_grant", grant, 0);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      settle();
      n++;
    end
    check("timeout_latency", n, 16);
    check("timeout_busy", busy, 0);
    tick();
    settle();
    check("timeout_pulse_single", timeout_err, 0);
    check("timeout_next_grant", grant, 2);
    check("timeout_next_busy", busy, 1);
`else
    n = 0;
    repeat (100) begin
      tick();
      settle();
      if (timeout_err) n++;
    end
    check("hold_busy", busy, 1);
    check("hold_grant", grant, 0);
    check("hold_other_ready", s_tready[2], 0);
    check("hold_m_tvalid", m_tvalid, 0);
    check("hold_no_timeout", n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
